up_down_counter_monitor: RTL
============================

# up_down_counter_monitor

Synthesizable passive checker that sits alongside `up_down_counter` in the lab-1 bench and consumes the same stimulus (`data_in`, `s_in`) plus the counter's `data_out`. It keeps its own reference copy of the counter, compares it against the DUT output every cycle and counts mismatches. It records the first failure for the report. It exists so the bench catches injected DUT bugs in hardware instead of by waveform inspection.

## Interface
- `WIDTH`, 8: counter data width.
- `ERR_W`, 16: width of the error and check counters; both saturate.
- `RESYNC`, 1: 1 = after a mismatch, rebase the model on the observed `data_out`; 0 = keep the model free-running.
- `STOP_ON_ERROR`, 0: 1 = freeze checking (HALT) on the first mismatch.
- `clk_in` input 1: clock; all state changes on the rising edge.
- `reset_in` input 1: asynchronous, active-low reset.
- `enable_in` input 1: checking enable.
- `data_in` input WIDTH: load value driven to the DUT.
- `s_in` input 2: DUT opcode.
  - 00 hold
  - 01 count up
  - 10 count down
  - 11 load `data_in`
- `data_out` input WIDTH: observed DUT counter output.
- `expected_out` output WIDTH: model value the DUT must show this cycle.
- `mismatch_out` output 1: one-cycle pulse per detected mismatch.
- `error_count_out` output ERR_W: number of mismatches, saturating.
- `check_count_out` output ERR_W: number of comparisons made, saturating.
- `first_err_valid_out` output 1: sticky flag; a first error has been captured.
- `first_err_observed_out` output WIDTH: `data_out` at the first mismatch.
- `first_err_expected_out` output WIDTH: `expected_out` at the first mismatch.
- `halted_out` output 1: high while in HALT.

## Operation
- `next(b)` is the next-state function applied to a base value `b`:
  - `s_in`=00: `b`
  - `s_in`=01: `b+1` mod 2^WIDTH (255→0)
  - `s_in`=10: `b-1` mod 2^WIDTH (0→255)
  - `s_in`=11: `data_in`
- States are IDLE, CHECK and HALT. Reset enters IDLE.
- IDLE, on each rising edge:
  - `exp_q <= next(data_out)`, so the model tracks the DUT with no comparison.
  - `enable_in`=1 moves to CHECK.
- CHECK, on each rising edge:
  - `cmp = (data_out != exp_q)`.
  - `base = (cmp && RESYNC) ? data_out : exp_q`.
  - `exp_q <= next(base)`.
  - `mismatch_out <= cmp`.
  - `error_count += cmp` and `check_count += 1`, both saturating at 2^ERR_W−1.
- First-error capture: if `cmp` and `first_err_valid_out`=0, latch the observed/expected pair and set `first_err_valid_out`. The flag stays set until reset.
- CHECK exits:
  - `cmp` with `STOP_ON_ERROR`=1 → HALT. This takes priority over `enable_in`.
  - Otherwise `enable_in`=0 → IDLE. The counters hold.
- HALT:
  - All registers hold, except `mismatch_out`, which returns to 0 on the next edge.
  - HALT is left only by reset.
- `expected_out` = `exp_q`, in every state.

## Timing
- Reset (`reset_in` low, asynchronous) forces all outputs to 0 immediately and the state to IDLE.
- Reset release is synchronous to the next rising edge. In the first cycle after release, `exp_q`=0.
- Comparisons are made in the cycle that `data_out` is presented. `mismatch_out`, the counters and the first-error fields update at the following rising edge: one cycle of latency.
- The model assumes the DUT is registered with zero extra latency: opcode/data applied in cycle n give `data_out` in cycle n+1.
- Entering CHECK from IDLE: the first comparison happens in the cycle after the edge on which `enable_in` was sampled high. No spurious mismatch is allowed at entry.
- `enable_in` falling: the comparison in that same cycle still counts. IDLE is entered at that edge.
- Simultaneous mismatch and `enable_in`=0: the error is counted; the next state is IDLE, or HALT if `STOP_ON_ERROR`=1.
- Reset mid-CHECK or mid-HALT clears everything, including the first-error fields.
- Counters at saturation stay at their maximum. There is no wrap and no other side effect.

## Test plan
- **Clean count:** reset, `enable_in`=1, load 8'hFE, then up ×3, then down ×3.
  - `expected_out` follows FE, FF, 00, 01, 00, FF, FE.
  - `error_count_out`=0 and `check_count_out`=7.
- **Single injected fault:** force `data_out`=8'h10 for one cycle while the model expects 8'h11, with `RESYNC`=1.
  - Exactly one `mismatch_out` pulse.
  - `error_count_out`=1.
  - First-error fields read 10/11.
  - Later correct DUT cycles produce no further mismatches.
- **No resync:** the same fault with `RESYNC`=0 and hold opcode for 5 cycles while the DUT keeps showing 10 and the model holds 11.
  - `error_count_out`=6.
  - The first-error fields are unchanged after the first capture.
- **Stop on error:** `STOP_ON_ERROR`=1, then a mismatch.
  - `halted_out`=1 one cycle later.
  - `error_count_out` stays 1 despite further mismatches.
  - Reset clears `halted_out` and `error_count_out`.
- **Enable gating:** `enable_in` low for 4 cycles while the DUT counts up.
  - `check_count_out` is frozen.
  - On re-enable, no mismatch occurs and `expected_out` equals the DUT's next value.
- **Async reset mid-run:** pulse `reset_in` low between clock edges.
  - All outputs read 0 before the next edge.
  - The state is IDLE.

Source files
------------

// File: rtl/up_down_counter_monitor.sv
// Passive checker for up_down_counter: keeps a reference copy of the counter,
// compares it with the observed data_out every cycle and counts mismatches.
module up_down_counter_monitor #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned ERR_W         = 16,
  parameter bit          RESYNC        = 1'b1,
  parameter bit          STOP_ON_ERROR = 1'b0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       s_in,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] expected_out,
  output logic             mismatch_out,
  output logic [ERR_W-1:0] error_count_out,
  output logic [ERR_W-1:0] check_count_out,
  output logic             first_err_valid_out,
  output logic [WIDTH-1:0] first_err_observed_out,
  output logic [WIDTH-1:0] first_err_expected_out,
  output logic             halted_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_exp, w_exp_nxt;
  logic             r_mis, w_mis_nxt;
  logic [ERR_W-1:0] r_err, w_err_nxt;
  logic [ERR_W-1:0] r_chk, w_chk_nxt;
  logic             r_fev, w_fev_nxt;
  logic [WIDTH-1:0] r_feo, w_feo_nxt;
  logic [WIDTH-1:0] r_fee, w_fee_nxt;
  logic             r_halt, w_halt_nxt;
  logic             w_cmp;
  logic [WIDTH-1:0] w_base;

  // Counter next-state function applied to an arbitrary base value
  function automatic logic [WIDTH-1:0] f_next(input logic [WIDTH-1:0] b,
                                              input logic [1:0]       s,
                                              input logic [WIDTH-1:0] d);
    case (s)
      2'b01:   f_next = b + WIDTH'(1);
      2'b10:   f_next = b - WIDTH'(1);
      2'b11:   f_next = d;
      default: f_next = b;
    endcase
  endfunction

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= ST_IDLE;
      r_exp   <= '0;
      r_mis   <= 1'b0;
      r_err   <= '0;
      r_chk   <= '0;
      r_fev   <= 1'b0;
      r_feo   <= '0;
      r_fee   <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_exp   <= w_exp_nxt;
      r_mis   <= w_mis_nxt;
      r_err   <= w_err_nxt;
      r_chk   <= w_chk_nxt;
      r_fev   <= w_fev_nxt;
      r_feo   <= w_feo_nxt;
      r_fee   <= w_fee_nxt;
      r_halt  <= w_halt_nxt;
    end
  end

  // Next-state and datapath; HALT falls through on the hold defaults
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_mis_nxt   = 1'b0;
    w_err_nxt   = r_err;
    w_chk_nxt   = r_chk;
    w_fev_nxt   = r_fev;
    w_feo_nxt   = r_feo;
    w_fee_nxt   = r_fee;
    w_cmp       = 1'b0;
    w_base      = r_exp;

    case (r_state)
      ST_IDLE: begin
        w_exp_nxt = f_next(data_out, s_in, data_in);
        if (enable_in) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        w_cmp     = (data_out != r_exp);
        w_base    = (w_cmp && RESYNC) ? data_out : r_exp;
        w_exp_nxt = f_next(w_base, s_in, data_in);
        w_mis_nxt = w_cmp;
        if (w_cmp && (r_err != CNT_MAX)) w_err_nxt = r_err + ERR_W'(1);
        if (r_chk != CNT_MAX)            w_chk_nxt = r_chk + ERR_W'(1);
        if (w_cmp && !r_fev) begin
          w_fev_nxt = 1'b1;
          w_feo_nxt = data_out;
          w_fee_nxt = r_exp;
        end
        if (w_cmp && STOP_ON_ERROR) w_state_nxt = ST_HALT;
        else if (!enable_in)        w_state_nxt = ST_IDLE;
      end
      ST_HALT: ;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_halt_nxt = (w_state_nxt == ST_HALT);
  end

  assign expected_out           = r_exp;
  assign mismatch_out           = r_mis;
  assign error_count_out        = r_err;
  assign check_count_out        = r_chk;
  assign first_err_valid_out    = r_fev;
  assign first_err_observed_out = r_feo;
  assign first_err_expected_out = r_fee;
  assign halted_out             = r_halt;

endmodule
